// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one load/store in flight, programmable wait
// states, one-cycle response strobe with held data/error.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clkIn,
  input  logic        resetIn,
  input  logic        reqValidIn,
  input  logic        reqWriteIn,
  input  logic [31:0] reqAddrIn,
  input  logic [31:0] reqWDataIn,
  input  logic [3:0]  reqByteEnIn,
  output logic        reqReadyOut,
  output logic        respValidOut,
  output logic [31:0] respDataOut,
  output logic        respErrOut,
  output logic        busyOut
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state, state_nxt;

  logic [3:0]  cnt;
  logic        wr_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic          accept, commit;
  logic          op_wr, op_err;
  logic [31:0]   op_addr, op_wdata;
  logic [3:0]    op_be;
  logic [AW-1:0] op_idx;

  assign accept = (state == S_IDLE) && reqValidIn && resetIn;

  // With zero wait states the commit edge is the accept edge, so the op comes straight
  // from the request inputs while IDLE and from the latched copy otherwise.
  always_comb begin
    op_wr    = wr_q;
    op_addr  = addr_q;
    op_wdata = wdata_q;
    op_be    = be_q;
    if (state == S_IDLE) begin
      op_wr    = reqWriteIn;
      op_addr  = reqAddrIn;
      op_wdata = reqWDataIn;
      op_be    = reqByteEnIn;
    end
  end

  assign op_idx = op_addr[AW+1:2];
  assign op_err = (op_addr[1:0] != 2'b00) || ((op_addr >> (AW + 2)) != 32'd0);
  assign commit = (state_nxt == S_RESP);

  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      S_WAIT:  if (cnt == 4'd0) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    reqReadyOut  = (state == S_IDLE) && resetIn;
    respValidOut = (state == S_RESP);
    busyOut      = (state != S_IDLE);
  end

  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      cnt         <= 4'd0;
      wr_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
      respDataOut <= 32'd0;
      respErrOut  <= 1'b0;
    end else begin
      if (accept) begin
        wr_q    <= reqWriteIn;
        addr_q  <= reqAddrIn;
        wdata_q <= reqWDataIn;
        be_q    <= reqByteEnIn;
        cnt     <= CNT_INIT;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        respErrOut  <= op_err;
        respDataOut <= (op_err || op_wr) ? 32'd0 : mem[op_idx];
      end
    end
  end

  // Storage survives reset; an abandoned store never reaches commit since reset forces IDLE.
  always_ff @(posedge clkIn) begin
    if (commit && op_wr && !op_err) begin
      for (int b = 0; b < 4; b++)
        if (op_be[b]) mem[op_idx][8*b +: 8] <= op_wdata[8*b +: 8];
    end
  end
endmodule
